// File: rtl/aes_dec_ctrl.sv
// Round sequencer for an iterative AES decryptor. It drives an external
// combinational inverse-round unit one round per cycle and latches the plaintext.
module aes_dec_ctrl (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      switch,
  input  logic [127:0]    in,
  input  logic [1919:0]   key_d,
  input  logic [127:0]    rnd_out,
  output logic [127:0]    rnd_in,
  output logic [127:0]    rnd_key,
  output logic            rnd_last,
  output logic [3:0]      rnd_idx,
  output logic            busy,
  output logic            done,
  output logic [127:0]    out
);

  // Handshake: start is a request that is taken only when busy=0 at a rising
  // edge; done pulses for exactly one cycle when out is updated, and busy=0 in
  // that cycle so a new start can be accepted immediately.
  typedef enum logic {
    IDLE  = 1'b0,
    ROUND = 1'b1
  } state_e;

  state_e         st_q, st_d;
  logic [127:0]   state_q, state_d;
  logic [127:0]   out_q, out_d;
  logic [3:0]     idx_q, idx_d;
  logic [3:0]     nr_q, nr_d;
  logic           done_q, done_d;
  logic [3:0]     nr_dec;
  logic [127:0]   key_slice [16];

  // Slice 15 never addressed (idx stays <= 14); tied off to keep the mux full.
  for (genvar g = 0; g < 15; g++) begin : g_slice
    assign key_slice[g] = key_d[128*g +: 128];
  end
  assign key_slice[15] = '0;

  always_comb begin
    case (switch)
      2'b00:   nr_dec = 4'd10;
      2'b01:   nr_dec = 4'd12;
      default: nr_dec = 4'd14;
    endcase
  end

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    out_d   = out_q;
    idx_d   = idx_q;
    nr_d    = nr_q;
    done_d  = 1'b0;
    case (st_q)
      IDLE: begin
        if (start) begin
          state_d = in ^ key_d[127:0];
          nr_d    = nr_dec;
          idx_d   = 4'd1;
          st_d    = ROUND;
        end
      end
      ROUND: begin
        if (idx_q == nr_q) begin
          out_d  = rnd_out;
          done_d = 1'b1;
          idx_d  = 4'd0;
          st_d   = IDLE;
        end else begin
          state_d = rnd_out;
          idx_d   = idx_q + 4'd1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      state_q <= '0;
      out_q   <= '0;
      idx_q   <= 4'd0;
      nr_q    <= 4'd10;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      nr_q    <= nr_d;
      done_q  <= done_d;
    end
  end

  assign rnd_in   = state_q;
  assign rnd_key  = key_slice[idx_q];
  assign rnd_last = (idx_q == nr_q);
  assign rnd_idx  = idx_q;
  assign busy     = (st_q == ROUND);
  assign done     = done_q;
  assign out      = out_q;

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Bench for aes_dec_ctrl: a software AES inverse-round unit closes the loop, and
// a timestamp model of whole-block decryption is compared against the DUT every cycle.
module tb_aes_dec_ctrl;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [1:0]     sw;
  logic [127:0]   ct;
  logic [1919:0]  kd;
  logic [127:0]   rnd_out, rnd_in, rnd_key, out;
  logic           rnd_last, busy, done;
  logic [3:0]     rnd_idx;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc   = 0;
  int lat;

  logic [7:0] sbox [256];
  logic [7:0] inv_sbox [256];
  logic       tbl_ok = 1'b0;

  aes_dec_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .switch(sw), .in(ct), .key_d(kd),
    .rnd_out(rnd_out), .rnd_in(rnd_in), .rnd_key(rnd_key), .rnd_last(rnd_last),
    .rnd_idx(rnd_idx), .busy(busy), .done(done), .out(out)
  );

  always #5 clk = ~clk;

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic int nk_of(input logic [1:0] s);
    return (s == 2'b00) ? 4 : (s == 2'b01) ? 6 : 8;
  endfunction

  // Builds the decryption-ordered schedule: slice k holds encryption round key nr-k.
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   tmp;
    logic [7:0]    rc;
    logic [1919:0] res;
    int            nr;
    nr  = nk + 6;
    rc  = 8'h01;
    res = '0;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int k = 0; k <= nr; k++)
      res[128*k +: 128] = {w[4*(nr-k)], w[4*(nr-k)+1], w[4*(nr-k)+2], w[4*(nr-k)+3]};
    return res;
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   o [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    for (int rr = 0; rr < 4; rr++)
      for (int c = 0; c < 4; c++)
        t[rr + 4*((c+rr)%4)] = inv_sbox[b[rr+4*c]];
    for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127-8*i -: 8];
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int rr = 0; rr < 4; rr++) o[4*c+rr] = t[4*c+rr];
      end else begin
        o[4*c]   = gmul(t[4*c],8'h0e)^gmul(t[4*c+1],8'h0b)^gmul(t[4*c+2],8'h0d)^gmul(t[4*c+3],8'h09);
        o[4*c+1] = gmul(t[4*c],8'h09)^gmul(t[4*c+1],8'h0e)^gmul(t[4*c+2],8'h0b)^gmul(t[4*c+3],8'h0d);
        o[4*c+2] = gmul(t[4*c],8'h0d)^gmul(t[4*c+1],8'h09)^gmul(t[4*c+2],8'h0e)^gmul(t[4*c+3],8'h0b);
        o[4*c+3] = gmul(t[4*c],8'h0b)^gmul(t[4*c+1],8'h0d)^gmul(t[4*c+2],8'h09)^gmul(t[4*c+3],8'h0e);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = o[i];
    return res;
  endfunction

  function automatic logic [127:0] aes_decrypt(input logic [127:0] c, input logic [1919:0] k,
                                               input int nr);
    logic [127:0] s;
    s = c ^ k[127:0];
    for (int r = 1; r <= nr; r++) s = inv_round(s, k[128*r +: 128], r == nr);
    return s;
  endfunction

  // External round unit
  assign rnd_out = tbl_ok ? inv_round(rnd_in, rnd_key, rnd_last) : '0;

  // ---------------- block-level model ----------------
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [127:0] m_out  = '0;
  logic [127:0] m_exp  = '0;
  int           m_acc  = 0;
  int           m_nr   = 10;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_done <= 1'b0;
    if (rst) begin
      m_busy <= 1'b0;
      m_out  <= '0;
    end else if (!m_busy && start) begin
      m_busy <= 1'b1;
      m_acc  <= cyc + 1;
      m_nr   <= nk_of(sw) + 6;
      m_exp  <= aes_decrypt(ct, kd, nk_of(sw) + 6);
    end else if (m_busy && (cyc + 1 == m_acc + m_nr)) begin
      m_busy <= 1'b0;
      m_done <= 1'b1;
      m_out  <= m_exp;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare of DUT against the model
  always @(posedge clk) begin
    int mi;
    #1;
    chk("busy", {127'b0, busy}, {127'b0, m_busy});
    chk("done", {127'b0, done}, {127'b0, m_done});
    chk("out", out, m_out);
    if (m_busy) begin
      mi = cyc - m_acc + 1;
      chk("rnd_idx", {124'b0, rnd_idx}, 128'(mi));
      chk("rnd_last", {127'b0, rnd_last}, {127'b0, (mi == m_nr)});
      chk("rnd_key", rnd_key, kd[128*mi +: 128]);
    end
  end

  // ---------------- driver tasks (called at posedge+2) ----------------
  task automatic launch(input logic [1:0] s, input logic [127:0] c, input logic [255:0] key);
    sw    = s;
    ct    = c;
    kd    = expand(key, nk_of(s));
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    acc   = cyc;
  endtask

  task automatic wait_done(output int l);
    l = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        l = cyc - acc + 1;
        #1;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL wait_done: no done within 40 cycles (cycle %0d)", cyc);
    #1;
  endtask

  task automatic wait_idx(input logic [3:0] target);
    for (int i = 0; i < 20; i++) begin
      if (rnd_idx == target) return;
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      logic [7:0] iv, sb;
      iv = 8'h01;
      for (int j = 0; j < 254; j++) iv = gmul(iv, 8'(a));
      sb = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]} ^ {iv[3:0], iv[7:4]} ^ 8'h63;
      sbox[a]      = sb;
      inv_sbox[sb] = 8'(a);
    end
    tbl_ok = 1'b1;

    // Reset wins over a simultaneous start
    rst   = 1'b1;
    start = 1'b1;
    sw    = 2'b00;
    ct    = C128;
    kd    = expand(K128, 4);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {127'b0, busy}, 128'd0);
    chk("rst_done", {127'b0, done}, 128'd0);
    chk("rst_out", out, 128'd0);
    chk("rst_idx", {124'b0, rnd_idx}, 128'd0);
    #1;
    rst = 1'b0;

    // AES-128, accepted on the first edge after reset
    launch(2'b00, C128, K128);
    wait_done(lat);
    chk("lat128", 128'(lat), 128'd11);
    chk("pt128", out, PT);

    @(posedge clk); #2;
    launch(2'b01, C192, K192);
    wait_done(lat);
    chk("lat192", 128'(lat), 128'd13);
    chk("pt192", out, PT);

    @(posedge clk); #2;
    launch(2'b10, C256, K256);
    wait_done(lat);
    chk("lat256a", 128'(lat), 128'd15);
    chk("pt256a", out, PT);

    @(posedge clk); #2;
    launch(2'b11, C256, K256);
    wait_done(lat);
    chk("lat256b", 128'(lat), 128'd15);
    chk("pt256b", out, PT);

    // Start and switch change while busy are ignored
    @(posedge clk); #2;
    launch(2'b00, C128, K128);
    wait_idx(4'd4);
    chk("reach_idx4", {124'b0, rnd_idx}, 128'd4);
    start = 1'b1;
    sw    = 2'b10;
    ct    = C256;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(lat);
    chk("lat_ignore", 128'(lat), 128'd11);
    chk("pt_ignore", out, PT);
    sw = 2'b00;

    // Back-to-back: new start in the done cycle
    @(posedge clk); #2;
    launch(2'b00, C128, K128);
    wait_done(lat);
    chk("pt_b2b_first", out, PT);
    launch(2'b00, 128'h0123456789abcdeffedcba9876543210, K128);
    wait_done(lat);
    chk("lat_b2b", 128'(lat), 128'd11);

    // Reset mid-block aborts with no done
    @(posedge clk); #2;
    launch(2'b00, C128, K128);
    wait_idx(4'd6);
    chk("reach_idx6", {124'b0, rnd_idx}, 128'd6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", {127'b0, busy}, 128'd0);
    chk("abort_out", out, 128'd0);
    chk("abort_done", {127'b0, done}, 128'd0);
    #1;
    rst = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    launch(2'b00, C128, K128);
    wait_done(lat);
    chk("lat_after_rst", 128'(lat), 128'd11);
    chk("pt_after_rst", out, PT);

    @(posedge clk); #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_dec_ctrl.md
AES_DEC_CTRL -- requirements
Module: aes_dec_ctrl

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL: rst  input  1  reset; synchronous and active-high.
REQ-003 SHALL: start  input  1  request to decrypt one block; sampled only while busy=0.
REQ-004 SHALL: switch  input  2  key size: 00=AES-128 (nr=10), 01=AES-192 (nr=12), 10/11=AES-256 (nr=14).
REQ-005 SHALL: in  input  128  ciphertext block, sampled at the start-accept edge.
REQ-006 SHALL: key_d  input  1920  expanded decryption schedule; slice k = key_d[128k+127:128k], k=0..nr; slice 0 = initial AddRoundKey key.
REQ-007 SHALL: rnd_out  input  128  result of the external combinational round unit for the current rnd_in/rnd_key.
REQ-008 SHALL: rnd_in  output  128  state register value driven to the round unit.
REQ-009 SHALL: rnd_key  output  128  round key slice key_d[128*idx+127:128*idx].
REQ-010 SHALL: rnd_last  output  1  high when idx==nr_q (final round, no InvMixColumns).
REQ-011 SHALL: rnd_idx  output  4  current round index idx.
REQ-012 SHALL: busy  output  1  high while a block is in progress.
REQ-013 SHALL: done  output  1  one-cycle pulse when out is updated.
REQ-014 SHALL: out  output  128  plaintext result register; holds until the next done.

Function
REQ-015 SHALL: implement states IDLE and ROUND; busy=1 exactly in ROUND.
REQ-016 SHALL: in IDLE with start=1 at edge E0: state_q<=in^key_d[127:0], nr_q<=decode(switch), idx<=1, go ROUND.
REQ-017 SHALL: in ROUND at each edge with idx<nr_q: state_q<=rnd_out, idx<=idx+1.
REQ-018 SHALL: in ROUND at the edge with idx==nr_q: out<=rnd_out, done<=1, idx<=0, go IDLE.
REQ-019 SHALL: give start-to-done latency of nr+1 edges: done high in the cycle after edge E(nr); 11/13/15 cycles for 128/192/256.
REQ-020 SHALL: hold done high for exactly one cycle; done=0 in every other cycle.
REQ-021 SHALL: ignore start while busy=1; no queuing.
REQ-022 SHALL: accept a start asserted in the done cycle (busy=0 there), giving back-to-back blocks with no idle gap.
REQ-023 SHALL: latch nr from switch only at start accept; switch changes while busy have no effect.
REQ-024 SHALL: read key_d combinationally every ROUND cycle; key_d stability while busy is the system's responsibility.
REQ-025 SHALL: drive rnd_in=state_q, rnd_key=slice idx and rnd_last=(idx==nr_q) in IDLE as well; these are don't-care and SHALL NOT be checked outside ROUND.
REQ-026 SHALL: size idx at 4 bits; idx never exceeds nr_q and never wraps.

Reset
REQ-027 SHALL: on rst=1 at an edge: state IDLE, busy=0, done=0, idx=0, nr_q=10, state_q=0, out=0.
REQ-028 SHALL: give rst priority over start and over round progress; a block in flight is aborted with no done and out=0.
REQ-029 SHALL: accept start on the first edge with rst=0.

Verification
REQ-030 SHALL: AES-128: switch=00, in=69c4e0d86a7b0430d8cdb78070b4c55a, key_d=schedule of 000102..0f -> done 11 cycles after start, out=00112233445566778899aabbccddeeff, rnd_last high only at idx=10.
REQ-031 SHALL: AES-192: switch=01, in=dda97ca4864cdfe06eaf70a0ec0d7191, key 000102..17 -> done after 13 cycles, out=00112233445566778899aabbccddeeff.
REQ-032 SHALL: AES-256: switch=10 and again switch=11, in=8ea2b7ca516745bfeafc49904b496089, key 000102..1f -> done after 15 cycles in both runs, same plaintext.
REQ-033 SHALL: start pulsed at idx=4 of a running AES-128 block, with switch toggled to 10 -> ignored; single done at cycle 11 with the correct AES-128 result.
REQ-034 SHALL: start asserted again in the done cycle with a new ciphertext -> second done exactly 11 cycles later; first out held until then.
REQ-035 SHALL: rst pulsed at idx=6 -> next cycle busy=0, out=0, no done; a fresh start then completes normally.
